flex_stp_word_rx: RTL and testbench

Parametrised serial-to-parallel receiver, successor to the flex serial-to-parallel shift register. Shifts serial bits into a NUM_BITS register with run-time selectable shift direction. Counts bits to detect word boundaries and hands each completed word to a held output buffer through a valid/ready handshake. Flags dropped words with a sticky overrun bit. Sits between a bit-level front end (e.g. a line decoder) and word-level consumers.

---
 rtl/flex_stp_word_rx.sv | 111 +++++++++++
 tb/tb_flex_stp_word_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/flex_stp_word_rx.sv
// rtl/flex_stp_word_rx.sv - serial-to-parallel word receiver with held output buffer and overrun flag
module flex_stp_word_rx #(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned RESET_VAL = 1,
  localparam int unsigned CNT_W    = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                msb_first,
  input  logic                clear,
  input  logic                word_ready,
  input  logic                overrun_clr,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic [CNT_W-1:0]    bit_count,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  output logic                overrun
);

  localparam logic [NUM_BITS-1:0] SR_RST   = NUM_BITS'(RESET_VAL);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic [NUM_BITS-1:0] sr_shift;
  logic                complete;
  logic                accept;

  // Shift candidate; direction is re-sampled on every shift so mid-word changes apply per bit
  always_comb begin
    sr_shift = sr_q;
    if (msb_first) begin
      sr_shift = {sr_q[NUM_BITS-2:0], serial_in};
    end else begin
      sr_shift = {serial_in, sr_q[NUM_BITS-1:1]};
    end
  end

  // Next-state: shift/clear, bit counting, word hand-off and overrun tracking
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    accept   = 1'b0;

    if (clear) begin
      sr_d  = SR_RST;
      cnt_d = '0;
    end else if (shift_enable) begin
      sr_d = sr_shift;
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Consumer takes the held word; a same-edge completion may refill it below
    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    if (overrun_clr) begin
      ovr_d = 1'b0;
    end

    // Buffer is free if empty or being drained this edge; otherwise the new word is lost
    if (complete) begin
      accept = !valid_q || word_ready;
      if (accept) begin
        word_d  = sr_shift;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_q    <= SR_RST;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = sr_q;
  assign bit_count    = cnt_q;
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_flex_stp_word_rx.sv
// tb/tb_flex_stp_word_rx.sv - directed self-checking bench for flex_stp_word_rx
module tb_flex_stp_word_rx;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic       serial_in;
  logic       msb_first;
  logic       clear;
  logic       word_ready;
  logic       overrun_clr;
  logic [7:0] parallel_out;
  logic [2:0] bit_count;
  logic [7:0] word_out;
  logic       word_valid;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  flex_stp_word_rx #(.NUM_BITS(8), .RESET_VAL(1)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .msb_first    (msb_first),
    .clear        (clear),
    .word_ready   (word_ready),
    .overrun_clr  (overrun_clr),
    .parallel_out (parallel_out),
    .bit_count    (bit_count),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift one bit in, leaving shift_enable low afterwards
  task automatic shift_bit(input logic b);
    serial_in    = b;
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
  endtask

  // Shift 8 bits, seq[7] first
  task automatic shift_word(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) begin
      shift_bit(seq[i]);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    step();
    checks++; if (parallel_out !== 8'h01) begin errors++; $display("FAIL reset_parallel_out: got %h expected 01", parallel_out); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word_out: got %h expected 00", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_rst = 1'b1;
  endtask

  task automatic test_msb_word();
    logic [7:0] seq;
    seq = 8'hA5;
    msb_first = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      shift_bit(seq[i]);
      checks++; if (bit_count !== 3'(8 - i)) begin errors++; $display("FAIL msb_bit_count: got %0d expected %0d", bit_count, 8 - i); end
    end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid: got %b expected 0", word_valid); end
    shift_bit(seq[0]);
    checks++; if (word_out !== 8'hA5) begin errors++; $display("FAIL msb_word_out: got %h expected a5", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL msb_word_valid: got %b expected 1", word_valid); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL msb_wrap_count: got %0d expected 0", bit_count); end
  endtask

  task automatic test_direction();
    word_ready = 1'b1;
    msb_first  = 1'b1;
    shift_word(8'b1100_0000);
    checks++; if (word_out !== 8'hC0) begin errors++; $display("FAIL dir_msb_word: got %h expected c0", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL dir_msb_valid: got %b expected 1", word_valid); end
    msb_first = 1'b0;
    shift_word(8'b1100_0000);
    checks++; if (word_out !== 8'h03) begin errors++; $display("FAIL dir_lsb_word: got %h expected 03", word_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL dir_overrun: got %b expected 0", overrun); end
    step();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL dir_consume_valid: got %b expected 0", word_valid); end
    checks++; if (word_out !== 8'h03) begin errors++; $display("FAIL dir_consume_hold: got %h expected 03", word_out); end
    word_ready = 1'b0;
    msb_first  = 1'b1;
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    shift_word(8'h3C);
    checks++; if (word_out !== 8'h3C) begin errors++; $display("FAIL ovr_first_word: got %h expected 3c", word_out); end
    shift_word(8'hF0);
    checks++; if (word_out !== 8'h3C) begin errors++; $display("FAIL ovr_word_held: got %h expected 3c", word_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (parallel_out !== 8'hF0) begin errors++; $display("FAIL ovr_parallel_out: got %h expected f0", parallel_out); end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b expected 0", word_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    word_ready = 1'b0;
    shift_word(8'h11);
    checks++; if (word_out !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h expected 11", word_out); end
    seq = 8'h22;
    for (int i = 7; i >= 1; i--) shift_bit(seq[i]);
    word_ready = 1'b1;
    shift_bit(seq[0]);
    word_ready = 1'b0;
    checks++; if (word_out !== 8'h22) begin errors++; $display("FAIL b2b_word: got %h expected 22", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", word_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_clear();
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b1);
    checks++; if (bit_count !== 3'd3) begin errors++; $display("FAIL clr_pre_count: got %0d expected 3", bit_count); end
    clear        = 1'b1;
    shift_enable = 1'b1;
    serial_in    = 1'b1;
    step();
    clear        = 1'b0;
    shift_enable = 1'b0;
    checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", bit_count); end
    checks++; if (parallel_out !== 8'h01) begin errors++; $display("FAIL clr_parallel_out: got %h expected 01", parallel_out); end
    checks++; if (word_out !== 8'h22) begin errors++; $display("FAIL clr_word_hold: got %h expected 22", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL clr_valid_hold: got %b expected 1", word_valid); end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    shift_word(8'h5A);
    checks++; if (word_out !== 8'h5A) begin errors++; $display("FAIL clr_next_word: got %h expected 5a", word_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid: got %b expected 1", word_valid); end
  endtask

  task automatic test_reset_mid();
    shift_word(8'h0F);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rmid_overrun_set: got %b expected 1", overrun); end
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    n_rst = 1'b0;
    #3;
    checks++; if (bit_count !== 3'd3) begin errors++; $display("FAIL rmid_between_count: got %0d expected 3", bit_count); end
    checks++; if (parallel_out !== 8'h7D) begin errors++; $display("FAIL rmid_between_sr: got %h expected 7d", parallel_out); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rmid_between_valid: got %b expected 1", word_valid); end
    step();
    checks++; if (parallel_out !== 8'h01) begin errors++; $display("FAIL rmid_sr: got %h expected 01", parallel_out); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", bit_count); end
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL rmid_word: got %h expected 00", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", word_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", overrun); end
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst        = 1'b0;
    shift_enable = 1'b0;
    serial_in    = 1'b0;
    msb_first    = 1'b1;
    clear        = 1'b0;
    word_ready   = 1'b0;
    overrun_clr  = 1'b0;
    test_reset();
    test_msb_word();
    test_direction();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
